// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and widths shared by the HI/LO multiply front-end
package mdu_pkg;
  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam logic [2:0] MDU_NOP   = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_MULT  = 3'b010;
  localparam logic [2:0] MDU_MTHI  = 3'b011;
  localparam logic [2:0] MDU_MTLO  = 3'b100;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// mdu_hilo_ctrl_if: start/ready handshake and operand/product bus to the external multiplier
interface mdu_hilo_ctrl_if;
  import mdu_pkg::*;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_product;
  logic              mul_ready;
  modport master (output mul_start, mul_a, mul_b, input mul_product, mul_ready);
  modport slave  (input mul_start, mul_a, mul_b, output mul_product, mul_ready);
endinterface

// File: rtl/mdu_sign_adjust.sv
// mdu_sign_adjust: operand magnitudes, result sign and conditional 64-bit product negation for MULT
module mdu_sign_adjust
  import mdu_pkg::*;
(
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              neg_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              neg_o,
  output logic [PROD_W-1:0] product_o
);
  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign a_o       = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
  assign b_o       = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
  assign neg_o     = signed_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
  assign product_o = neg_i ? -product_i : product_i;
endmodule

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: sequences the external shift-add multiplier and owns HI/LO; MDU_SIGNED_EN enables MULT sign correction
module mdu_hilo_ctrl
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  mdu_hilo_ctrl_if.master   mul
);
  state_t            state_q;
  logic              busy_q, done_q, start_q, is_mul;
  logic [DATA_W-1:0] hi_q, lo_q, a_q, b_q, a_d, b_d;
  logic [PROD_W-1:0] prod_d;
  assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_SIGNED_EN
  logic neg_q, neg_d;
  mdu_sign_adjust u_sign (
    .signed_i (op == MDU_MULT),
    .a_i      (rs_val),
    .b_i      (rt_val),
    .neg_i    (neg_q),
    .product_i(mul.mul_product),
    .a_o      (a_d),
    .b_o      (b_d),
    .neg_o    (neg_d),
    .product_o(prod_d)
  );
  // Result sign is latched with the operands so the product can be corrected at capture
  always_ff @(posedge clk) begin
    if (!reset_n) neg_q <= 1'b0;
    else if (state_q == IDLE && op_valid && is_mul) neg_q <= neg_d;
  end
`else
  assign a_d    = rs_val;
  assign b_d    = rt_val;
  assign prod_d = mul.mul_product;
`endif
  // Control FSM: accept in IDLE, one-cycle start, wait for ready, one-cycle done
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (op_valid && is_mul) begin
            state_q <= START;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
          end else if (op_valid && op == MDU_MTHI) hi_q <= rs_val;
          else if (op_valid && op == MDU_MTLO) lo_q <= rs_val;
        START: begin
          state_q <= WAIT;
          start_q <= 1'b0;
        end
        WAIT:
          if (mul.mul_ready) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= prod_d;
          end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign mul.mul_start = start_q;
  assign mul.mul_a     = a_q;
  assign mul.mul_b     = b_q;
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: scoreboard bench with a behavioural multiplier and arithmetic reference model
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;
`ifdef MDU_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, op_valid = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] rs_val = 32'b0, rt_val = 32'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  mdu_hilo_ctrl_if mif ();
  mdu_hilo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .mul(mif)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          cyc;
    logic [63:0] v;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t        sq[$], dq[$];
  exp_t        ms, md;
  int          cyc = 0, errors = 0, checks = 0, busy_cnt = 0;
  logic [31:0] hi_m = 0, lo_m = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] ref_prod(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (o == MDU_MULT && SIGNED_EN) return sa * sb;
    return {32'b0, a} * {32'b0, b};
  endfunction
  function automatic logic [31:0] mag(input logic [2:0] o, input logic [31:0] x);
    return (o == MDU_MULT && SIGNED_EN && x[31]) ? -x : x;
  endfunction
  // Multiplier model: counter restarts on start, ready pulses 257 cycles after the start cycle
  initial begin
    int          cnt;
    logic [63:0] p;
    cnt = 0;
    p = 0;
    mif.mul_ready = 1'b0;
    mif.mul_product = 64'b0;
    forever begin
      @(posedge clk);
      #1;
      mif.mul_ready = 1'b0;
      if (mif.mul_start) begin
        p = {32'b0, mif.mul_a} * {32'b0, mif.mul_b};
        cnt = 257;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mif.mul_ready = 1'b1;
          mif.mul_product = p;
        end
      end
    end
  end
  // Monitor: pops expectations whenever the DUT pulses mul_start or done
  initial forever begin
    @(negedge clk);
    if (!reset_n) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (mif.mul_start) begin
      if (sq.size() == 0) chk("unexpected_start", mif.mul_start, 0);
      else begin
        ms = sq.pop_front();
        chk("start_cycle", cyc, ms.cyc);
        chk("mul_a", mif.mul_a, ms.a);
        chk("mul_b", mif.mul_b, ms.b);
        chk("busy_at_start", busy, 1);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        md = dq.pop_front();
        chk("done_cycle", cyc, md.cyc);
        chk("hilo", {hi, lo}, md.v);
        chk("busy_cycles", busy_cnt, 258);
        chk("busy_at_done", busy, 0);
        busy_cnt = 0;
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask
  task automatic start_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.cyc = cyc + 1;
    e.a = mag(o, a);
    e.b = mag(o, b);
    e.v = 64'b0;
    sq.push_back(e);
    e.cyc = cyc + 259;
    e.v = ref_prod(o, a, b);
    dq.push_back(e);
    hi_m = e.v[63:32];
    lo_m = e.v[31:0];
    issue(o, a, b);
  endtask
  task automatic wait_done;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dq.size() > 0 && n < 400);
    if (dq.size() > 0) begin
      chk("done_timeout", dq.size(), 0);
      dq.delete();
      sq.delete();
    end
  endtask
  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    issue(o, v, $urandom);
    if (o == MDU_MTHI) hi_m = v;
    else if (o == MDU_MTLO) lo_m = v;
    chk("hi_after_op", hi, hi_m);
    chk("lo_after_op", lo, lo_m);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] old_hi, old_lo, a, b;
    logic [2:0]  o;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", mif.mul_start, 0);
    chk("rst_mul_a", mif.mul_a, 0);
    chk("rst_mul_b", mif.mul_b, 0);
    reset_n = 1'b1;
    start_mul(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    start_mul(MDU_MULT, 32'hFFFFFFFD, 32'h00000007);
    wait_done();
    start_mul(MDU_MULT, 32'h80000000, 32'h80000000);
    wait_done();
    start_mul(MDU_MULT, 32'h80000000, 32'h00000001);
    wait_done();
    mt(MDU_MTHI, 32'h12345678);
    mt(MDU_MTLO, 32'h9ABCDEF0);
    old_hi = hi_m;
    old_lo = lo_m;
    start_mul(MDU_MULT, $urandom, $urandom);
    repeat (50) @(posedge clk);
    #1;
    issue(MDU_MTLO, 32'hDEADBEEF, 0);
    chk("lo_mtlo_busy", lo, old_lo);
    chk("hi_mtlo_busy", hi, old_hi);
    issue(MDU_MULTU, 32'h5, 32'h5);
    wait_done();
    start_mul(MDU_MULTU, $urandom, $urandom);
    repeat (258) @(posedge clk);
    #1;
    issue(MDU_MTLO, 32'h55555555, 0);
    chk("lo_done_cycle_op", lo, lo_m);
    start_mul(MDU_MULTU, $urandom, $urandom);
    wait_done();
    mt(MDU_MTHI, 32'hCAFEF00D);
    start_mul(MDU_MULTU, $urandom, $urandom);
    repeat (99) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset_n = 1'b1;
    dq.delete();
    sq.delete();
    hi_m = 0;
    lo_m = 0;
    start_mul(MDU_MULTU, 32'd2, 32'd3);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (o == MDU_MULT || o == MDU_MULTU) begin
        start_mul(o, a, b);
        wait_done();
      end else mt(o, a);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_hilo_ctrl.md
# mdu_hilo_ctrl

Sequencing front-end for the shift-add multiplier in the multi-cycle MIPS datapath. Accepts MULT/MULTU/MTHI/MTLO operations from the main control FSM and drives the multiplier's start/ready handshake. Applies sign correction for signed multiplies and owns the architectural HI/LO registers. Asserts busy so the control FSM stalls until the result is committed.

## Interface
Parameters:
- none; widths fixed at 32-bit operands and 64-bit product.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset_n  input  1  synchronous, active-low reset
- op_valid  input  1  operation request strobe, one cycle
- op  input  3  000 NOP, 001 MULTU, 010 MULT, 011 MTHI, 100 MTLO, others NOP
- rs_val  input  32  operand A / MTHI/MTLO data
- rt_val  input  32  operand B
- busy  output  1  multiply in flight; control must stall
- done  output  1  one-cycle pulse when HI/LO updated by a multiply
- hi  output  32  HI register
- lo  output  32  LO register
- mul_start  output  1  start pulse to multiplier
- mul_a  output  32  multiplier operand A (registered)
- mul_b  output  32  multiplier operand B (registered)
- mul_product  input  64  multiplier product
- mul_ready  input  1  multiplier ready

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - op_valid with MULT/MULTU: latch operands, latch sign flag, go to START.
  - MTHI/MTLO: write rs_val to hi/lo at the clock edge, stay IDLE, no done pulse.
  - NOP or undefined op: no effect.
- START: mul_start=1 for exactly one cycle; mul_a/mul_b stable; go to WAIT.
- WAIT: mul_ready sampled only in this state. When mul_ready=1, capture the corrected product into {hi,lo}, then go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- op_valid outside IDLE is ignored, with no state or HI/LO change. The control FSM is responsible for not issuing while busy.
- Signed (MULT):
  - mul_a = |rs_val| and mul_b = |rt_val|, using 32-bit two's-complement absolute value. -2^31 maps to 0x80000000, which is correct as an unsigned value.
  - If rs_val[31] xor rt_val[31], the 64-bit product is negated (~p+1) before capture.
- Unsigned (MULTU): operands passed through unchanged; no negation.
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, mul_start=0, mul_a=0, mul_b=0.
- Reset mid-operation: return to IDLE, HI/LO cleared. The multiplier may keep running; its mul_ready is not sampled until the next WAIT.

## Timing
- Request accepted in cycle T (IDLE, op_valid=1).
- T+1: START, mul_start=1, busy=1.
- T+2 onward: WAIT. The multiplier counter restarts at 0 and raises mul_ready 256 cycles later, so mul_ready=1 in cycle T+258.
- T+259: DONE. done=1, busy=0, and new hi/lo are visible.
- Multiply latency: 259 cycles from accept to done.
- busy is high in cycles T+1..T+258 (states START and WAIT).
- MTHI/MTLO latency: 1 cycle; value visible the cycle after op_valid.
- A back-to-back op_valid in the DONE cycle is ignored. The next op is accepted at T+260 at the earliest.

## Configuration
- MDU_SIGNED_EN defined: MULT is sign-corrected as described above.
- MDU_SIGNED_EN undefined:
  - MULT is treated exactly as MULTU (raw operands, no negation).
  - The sign-correction logic is removed entirely.

## Structure
- Shared package mdu_pkg holds:
  - op encoding constants (MDU_NOP, MDU_MULTU, MDU_MULT, MDU_MTHI, MDU_MTLO)
  - FSM state encoding
  - operand/product width constants (32/64)
- One sub-module, mdu_sign_adjust. It is purely combinational and provides:
  - operand absolute value and sign-xor generation
  - 64-bit conditional negation of the product
- The whole sub-module is instantiated only under MDU_SIGNED_EN.
- The multiplier itself is external and is connected through the mul_* ports.

## Test plan
- Reset, then idle: after reset_n low for 2 cycles, hi=lo=0, busy=0, done=0, mul_start=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: mul_start pulses at T+1, done at T+259, {hi,lo}=0xFFFFFFFE_00000001, busy high for exactly 258 cycles.
- MULT -3 × 7 (0xFFFFFFFD, 0x00000007), MDU_SIGNED_EN defined: mul_a=3, mul_b=7, {hi,lo}=0xFFFFFFFF_FFFFFFEB.
  - Same stimulus without the macro: {hi,lo}=0x00000006_FFFFFFEB.
- MULT 0x80000000 × 0x80000000 (signed): {hi,lo}=0x40000000_00000000.
  - MULT 0x80000000 × 1: {hi,lo}=0xFFFFFFFF_80000000.
- MTHI 0x12345678, next cycle MTLO 0x9ABCDEF0: hi/lo updated one cycle after each request, no done pulse.
  - MTLO issued while busy: lo unchanged, and the multiply result still lands correctly.
- Reset asserted at T+100 of a multiply: IDLE, hi=lo=0, busy=0 next cycle, no done pulse.
  - A new MULTU 2×3 issued afterwards completes with {hi,lo}=0x00000000_00000006 at accept+259.
